// File: rtl/prbs_lock_checker.sv
// rtl/prbs_lock_checker.sv - LFSR sequence lock checker with saturating error count.
// Optional err_sticky output enabled by defining PRBS_CHK_STICKY_ERR_EN.
// State word bit k of [1:WIDTH] lives at vector index k-1 (TAPS uses the same mapping).

module prbs_lock_checker #(
  parameter int                 WIDTH      = 26,
  parameter logic [WIDTH-1:0]   TAPS       = 26'h2000023,
  parameter int                 LOCK_CNT   = 4,
  parameter int                 UNLOCK_CNT = 4,
  parameter int                 CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
`ifdef PRBS_CHK_STICKY_ERR_EN
  output logic             err_sticky,
`endif
  output logic             zero_det
);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               have_prev_q, have_prev_d;
  logic [3:0]         good_run_q, good_run_d;
  logic [3:0]         bad_run_q, bad_run_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic               zero_det_q, zero_det_d;
  logic               sticky_q, sticky_d;

  logic               fb;
  logic [WIDTH-1:0]   succ;
  logic               match;

  // Expected next word and match decision for the word presented this cycle
  always_comb begin
    fb    = ^(prev_q & TAPS);
    succ  = {prev_q[WIDTH-2:0], fb};
    match = have_prev_q && (din == succ) && (din != '0);
  end

  // Next-state: HUNT/LOCK FSM, run counters, error count and sticky flag
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    good_run_d  = good_run_q;
    bad_run_d   = bad_run_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    zero_det_d  = zero_det_q;
    sticky_d    = sticky_q;

    if (en) begin
      prev_d      = din;
      have_prev_d = 1'b1;
      zero_det_d  = (din == '0);

      case (state_q)
        HUNT: begin
          if (match) begin
            if (good_run_q == 4'(LOCK_CNT - 1)) begin
              state_d    = LOCK;
              good_run_d = '0;
              bad_run_d  = '0;
            end else begin
              good_run_d = good_run_q + 4'd1;
            end
          end else begin
            good_run_d = '0;
          end
        end
        LOCK: begin
          if (match) begin
            bad_run_d = '0;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            // The unlocking mismatch is still counted above
            if (bad_run_q == 4'(UNLOCK_CNT - 1)) begin
              state_d    = HUNT;
              bad_run_d  = '0;
              good_run_d = '0;
            end else begin
              bad_run_d = bad_run_q + 4'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    if (err_d) begin
      sticky_d = 1'b1;
    end

    // Clear beats a same-cycle error for the counter and sticky flag
    if (clr) begin
      err_cnt_d = '0;
      sticky_d  = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      good_run_q  <= '0;
      bad_run_q   <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      zero_det_q  <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      good_run_q  <= good_run_d;
      bad_run_q   <= bad_run_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      zero_det_q  <= zero_det_d;
      sticky_q    <= sticky_d;
    end
  end

  assign locked   = (state_q == LOCK);
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;
  assign zero_det = zero_det_q;

`ifdef PRBS_CHK_STICKY_ERR_EN
  assign err_sticky = sticky_q;
`else
  logic unused_sticky;
  assign unused_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_prbs_lock_checker.sv
// tb/tb_prbs_lock_checker.sv - scoreboard bench for prbs_lock_checker (main and CNT_W=3 instances).
// Checks err_sticky too when PRBS_CHK_STICKY_ERR_EN is defined.

module tb_prbs_lock_checker;

  typedef struct {
    logic        locked;
    logic        err;
    logic [15:0] cnt;
    logic        zero;
    logic        sticky;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        en = 1'b0, clr = 1'b0;
  logic [25:0] din = '0;
  logic        locked, err, zero_det;
  logic [15:0] err_cnt;
  logic        err_sticky;

  logic        en2 = 1'b0, clr2 = 1'b0;
  logic [25:0] din2 = '0;
  logic        locked2, err2, zero_det2;
  logic [2:0]  err_cnt2;
  logic        err_sticky2;

  exp_t q[$];
  exp_t q2[$];
  int   checks = 0;
  int   errors = 0;
  logic sticky_m = 1'b0;
  logic sticky_m2 = 1'b0;

  always #5 clk = ~clk;

  prbs_lock_checker dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt),
`ifdef PRBS_CHK_STICKY_ERR_EN
    .err_sticky(err_sticky),
`endif
    .zero_det(zero_det)
  );

  prbs_lock_checker #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en2), .din(din2), .clr(clr2),
    .locked(locked2), .err(err2), .err_cnt(err_cnt2),
`ifdef PRBS_CHK_STICKY_ERR_EN
    .err_sticky(err_sticky2),
`endif
    .zero_det(zero_det2)
  );

`ifndef PRBS_CHK_STICKY_ERR_EN
  assign err_sticky  = 1'b0;
  assign err_sticky2 = 1'b0;
`endif

  // Reference successor with taps s[26], s[6], s[2], s[1] written out explicitly
  function automatic logic [25:0] nxt(input logic [25:0] s);
    logic f;
    f = s[25] ^ s[5] ^ s[1] ^ s[0];
    return {s[24:0], f};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic e, input logic [25:0] d, input logic c,
                      input logic el, input logic ee, input logic [15:0] ec, input logic ez);
    exp_t x;
    en = e; din = d; clr = c;
    @(posedge clk);
    if (c) sticky_m = 1'b0;
    else if (ee) sticky_m = 1'b1;
    x.locked = el; x.err = ee; x.cnt = ec; x.zero = ez; x.sticky = sticky_m;
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic step2(input logic e, input logic [25:0] d, input logic c,
                       input logic el, input logic ee, input logic [15:0] ec);
    exp_t x;
    en2 = e; din2 = d; clr2 = c;
    @(posedge clk);
    if (c) sticky_m2 = 1'b0;
    else if (ee) sticky_m2 = 1'b1;
    x.locked = el; x.err = ee; x.cnt = ec; x.zero = 1'b0; x.sticky = sticky_m2;
    q2.push_back(x);
    @(negedge clk);
  endtask

  // Monitor for the main instance
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("locked", 32'(locked), 32'(x.locked));
      chk("err", 32'(err), 32'(x.err));
      chk("err_cnt", 32'(err_cnt), 32'(x.cnt));
      chk("zero_det", 32'(zero_det), 32'(x.zero));
`ifdef PRBS_CHK_STICKY_ERR_EN
      chk("err_sticky", 32'(err_sticky), 32'(x.sticky));
`endif
    end
  end

  // Monitor for the narrow-counter instance
  always @(negedge clk) begin
    if (q2.size() > 0) begin
      exp_t x;
      x = q2.pop_front();
      chk("sat_locked", 32'(locked2), 32'(x.locked));
      chk("sat_err", 32'(err2), 32'(x.err));
      chk("sat_err_cnt", 32'(err_cnt2), 32'(x.cnt));
`ifdef PRBS_CHK_STICKY_ERR_EN
      chk("sat_err_sticky", 32'(err_sticky2), 32'(x.sticky));
`endif
    end
  end

  initial begin
    logic [25:0] w;
    int          n;

    #12;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_zero_det", 32'(zero_det), 32'd0);
    chk("rst_sat_err_cnt", 32'(err_cnt2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Lock acquisition: seed + 4 successors
    w = 26'h3656B59;
    chk("succ_seed", 32'(nxt(w)), 32'h2CAD6B2);
    step(1, w, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      w = nxt(w);
      step(1, w, 0, (i == 4), 0, 0, 0);
    end
    w = nxt(w); step(1, w, 0, 1, 0, 0, 0);

    // Single corruption: two mismatches, lock held
    w = nxt(w); step(1, w ^ 26'h1, 0, 1, 1, 1, 0);
    w = nxt(w); step(1, w, 0, 1, 1, 2, 0);
    w = nxt(w); step(1, w, 0, 1, 0, 2, 0);
    w = nxt(w); step(1, w, 1, 1, 0, 0, 0);

    // Loss of lock after 4 foreign words
    step(1, 26'h0000001, 0, 1, 1, 1, 0);
    step(1, 26'h0000100, 0, 1, 1, 2, 0);
    step(1, 26'h0002000, 0, 1, 1, 3, 0);
    step(1, 26'h00ABCDE, 0, 0, 1, 4, 0);

    // Re-lock with en toggling
    w = 26'h1234567;
    step(1, w, 0, 0, 0, 4, 0);
    step(0, 26'h0, 0, 0, 0, 4, 0);
    for (int i = 1; i <= 4; i++) begin
      w = nxt(w);
      step(1, w, 0, (i == 4), 0, 4, 0);
      step(0, 26'h0, 0, (i == 4), 0, 4, 0);
    end

    // Zero word in LOCK
    w = nxt(w); step(1, w, 0, 1, 0, 4, 0);
    step(1, 26'h0, 0, 1, 1, 5, 1);

    // Asynchronous reset between edges
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    sticky_m = 1'b0;
    chk("async_locked", 32'(locked), 32'd0);
    chk("async_err_cnt", 32'(err_cnt), 32'd0);
    chk("async_zero_det", 32'(zero_det), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w = nxt(w); step(1, w, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      w = nxt(w);
      step(1, w, 0, (i == 4), 0, 0, 0);
    end
    en = 1'b0;

    // Saturation on the 3-bit counter instance
    w = 26'h3656B59;
    step2(1, w, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      w = nxt(w);
      step2(1, w, 0, (i == 4), 0, 0);
    end
    n = 0;
    for (int r = 0; r < 5; r++) begin
      w = nxt(w); n++; step2(1, w ^ 26'h1, 0, 1, 1, 16'((n > 7) ? 7 : n));
      w = nxt(w); n++; step2(1, w, 0, 1, 1, 16'((n > 7) ? 7 : n));
      w = nxt(w);      step2(1, w, 0, 1, 0, 16'((n > 7) ? 7 : n));
    end
    w = nxt(w); step2(1, w, 1, 1, 0, 0);
    w = nxt(w); step2(1, w ^ 26'h1, 1, 1, 1, 0);
    w = nxt(w); step2(1, w, 0, 1, 1, 1);
    en2 = 1'b0;

    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(q.size() + q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
